// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and default width for the sequential ALU slice.
// Optional divider is enabled by defining SEQ_ALU_DIV_EN.
package alu_pkg;
   localparam int DEF_WIDTH = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_DIV = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/seq_alu_if.sv
// Start/busy/done handshake between the control unit (master) and seq_alu (slave).
interface seq_alu_if import alu_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
) ();
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             err;

   modport master (output start, op, a, b,
                   input  busy, done, result, carry, zero, err);
   modport slave  (input  start, op, a, b,
                   output busy, done, result, carry, zero, err);
endinterface

// File: rtl/alu_iter_unit.sv
// Shared accumulator/shift datapath for SHL, MUL and (with SEQ_ALU_DIV_EN) DIV.
// Outputs show the value the registers take after the current iterate edge.
module alu_iter_unit import alu_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_iter,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_res,
   output logic             o_flag
);
   logic [WIDTH-1:0] r_acc, r_aux;
   logic             r_cf;
   logic [WIDTH-1:0] w_acc_nxt, w_aux_nxt;
   logic             w_cf_nxt;
   logic [WIDTH:0]   w_sum;
`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH:0]   w_rem;
   logic [WIDTH:0]   w_diff;
`endif

   always_comb begin
      w_acc_nxt = r_acc;
      w_aux_nxt = r_aux;
      w_cf_nxt  = r_cf;
      w_sum     = '0;
`ifdef SEQ_ALU_DIV_EN
      w_rem     = '0;
      w_diff    = '0;
`endif
      case (i_op)
         OP_SHL: begin
            w_cf_nxt  = r_aux[WIDTH-1];
            w_aux_nxt = {r_aux[WIDTH-2:0], 1'b0};
         end
         // acc holds the high product half, aux the multiplier shifting out into the low half
         OP_MUL: begin
            w_sum = {1'b0, r_acc} + (r_aux[0] ? {1'b0, i_a} : '0);
            {w_acc_nxt, w_aux_nxt} = {w_sum, r_aux[WIDTH-1:1]};
         end
`ifdef SEQ_ALU_DIV_EN
         OP_DIV: begin
            w_rem  = {r_acc, r_aux[WIDTH-1]};
            w_diff = w_rem - {1'b0, i_b};
            if (!w_diff[WIDTH]) begin
               w_acc_nxt = w_diff[WIDTH-1:0];
               w_aux_nxt = {r_aux[WIDTH-2:0], 1'b1};
            end else begin
               w_acc_nxt = w_rem[WIDTH-1:0];
               w_aux_nxt = {r_aux[WIDTH-2:0], 1'b0};
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc <= '0;
         r_aux <= '0;
         r_cf  <= 1'b0;
      end else if (i_load) begin
         r_acc <= '0;
         r_aux <= (i_op == OP_MUL) ? i_b : i_a;
         r_cf  <= 1'b0;
      end else if (i_iter) begin
         r_acc <= w_acc_nxt;
         r_aux <= w_aux_nxt;
         r_cf  <= w_cf_nxt;
      end
   end

   assign o_res  = w_aux_nxt;
   assign o_flag = (i_op == OP_SHL) ? w_cf_nxt : (w_acc_nxt != '0);
endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU stage: IDLE/RUN FSM, iteration counter, single-cycle ops and flag registers.
// Op 111 is a restoring divider when SEQ_ALU_DIV_EN is defined, otherwise an error op.
module seq_alu import alu_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic     clk,
   input  logic     async_reset,
   seq_alu_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int SH_W  = $clog2(WIDTH);

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_init;
   logic [2:0]       r_op, w_op;
   logic [WIDTH-1:0] r_a, r_b, w_a, w_b;
   logic [WIDTH-1:0] r_result, w_res, w_ires;
   logic             r_done, r_carry, r_zero, r_err;
   logic             w_load, w_last, w_run, w_cy, w_er, w_iflag;
   logic [WIDTH:0]   w_sum, w_dif;

   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) r_state <= ST_IDLE;
      else             r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (bus.start) w_next = ST_RUN;
         ST_RUN:  if (r_cnt == CNT_W'(1)) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_run      = (r_state == ST_RUN);
      w_load     = (r_state == ST_IDLE) && bus.start;
      w_last     = w_run && (r_cnt == CNT_W'(1));
      w_cnt_init = CNT_W'(1);
      w_res      = '0;
      w_cy       = 1'b0;
      w_er       = 1'b0;
      w_sum      = {1'b0, r_a} + {1'b0, r_b};
      w_dif      = {1'b0, r_a} - {1'b0, r_b};
      case (bus.op)
         OP_SHL: if (bus.b[SH_W-1:0] != '0) w_cnt_init = CNT_W'(bus.b[SH_W-1:0]);
         OP_MUL: w_cnt_init = CNT_W'(WIDTH);
`ifdef SEQ_ALU_DIV_EN
         OP_DIV: if (bus.b != '0) w_cnt_init = CNT_W'(WIDTH);
`endif
         default: ;
      endcase
      case (r_op)
         OP_ADD: {w_cy, w_res} = w_sum;
         OP_SUB: {w_cy, w_res} = w_dif;
         OP_AND: w_res = r_a & r_b;
         OP_OR:  w_res = r_a | r_b;
         OP_XOR: w_res = r_a ^ r_b;
         // a zero shift still spends one cycle but bypasses the shifter
         OP_SHL: begin
            if (r_b[SH_W-1:0] == '0) w_res = r_a;
            else begin
               w_res = w_ires;
               w_cy  = w_iflag;
            end
         end
         OP_MUL: begin
            w_res = w_ires;
            w_cy  = w_iflag;
         end
         OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
            if (r_b == '0) begin
               w_res = '1;
               w_er  = 1'b1;
            end else begin
               w_res = w_ires;
               w_cy  = w_iflag;
            end
`else
            w_er = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   // The iterative unit loads from the live bus at start, then steps on latched operands
   assign w_op = (r_state == ST_IDLE) ? bus.op : r_op;
   assign w_a  = (r_state == ST_IDLE) ? bus.a  : r_a;
   assign w_b  = (r_state == ST_IDLE) ? bus.b  : r_b;

   alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .i_rst  (async_reset),
      .i_load (w_load),
      .i_iter (w_run),
      .i_op   (w_op),
      .i_a    (w_a),
      .i_b    (w_b),
      .o_res  (w_ires),
      .o_flag (w_iflag)
   );

   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         r_cnt    <= '0;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_load) begin
            r_op  <= bus.op;
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_cnt <= w_cnt_init;
         end else if (w_run) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_last) begin
            r_result <= w_res;
            r_carry  <= w_cy;
            r_zero   <= (w_res == '0);
            r_err    <= w_er;
         end
      end
   end

   assign bus.busy   = (r_state == ST_RUN);
   assign bus.done   = r_done;
   assign bus.result = r_result;
   assign bus.carry  = r_carry;
   assign bus.zero   = r_zero;
   assign bus.err    = r_err;
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle 8-bit ALU stage for the simple processor.
- Consumes the q outputs of two operand registers and produces a registered result that drives the d input of the accumulator register.
- Uses a start/busy/done handshake with the control unit.
- Single-cycle ops (add/sub/logic) and iterative ops (shift, multiply, optional divide) share one RUN state driven by an iteration counter.

Parameters:
WIDTH, 8, operand/result width in bits (power of 2, >= 4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
async_reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  3  opcode, latched with start
a  input  WIDTH  operand A, latched with start
b  input  WIDTH  operand B, latched with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse: result/flags just updated
result  output  WIDTH  registered result, held until next completion
carry  output  1  carry/borrow/overflow flag
zero  output  1  result == 0
err  output  1  illegal or divide-by-zero

Behaviour:
- Clock and reset:
  - One clock domain.
  - async_reset=1 immediately forces state IDLE, busy=0, done=0, result=0, carry=0, zero=0, err=0, counter=0.
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR: 1 iteration.
  - 101 SHL by b[$clog2(WIDTH)-1:0]: 1 bit per cycle; shift amount 0 still takes 1 iteration.
  - 110 MUL: shift-add, WIDTH iterations.
  - 111 DIV: restoring division, WIDTH iterations (optional feature).
- FSM states IDLE, RUN:
  - IDLE & start at edge t: latch a, b, op; load counter with N; go RUN; busy=1 from t.
  - RUN: one iteration per edge, counter decrements. At edge t+N, write result/flags, pulse done=1 for exactly one cycle, drop busy=0, return to IDLE.
- Handshake:
  - start while busy=1 is ignored; no queueing.
  - start in the same cycle done=1 is accepted (back-to-back, no idle bubble).
- Flags (updated only at completion):
  - ADD: carry = carry-out.
  - SUB: carry = borrow (a<b unsigned).
  - Logic ops: carry = 0.
  - SHL: carry = last bit shifted out (0 if shift amount is 0).
  - MUL: result = low WIDTH bits; carry = 1 if high product bits are non-zero.
  - zero = (result == 0) for every op. err = 0 unless stated.
- Boundaries:
  - All arithmetic is unsigned, modulo 2^WIDTH.
  - Operand changes after start have no effect.
  - async_reset mid-RUN aborts the operation: no done pulse, result=0.

Optional Feature:
- Macro: SEQ_ALU_DIV_EN.
- Defined: op 111 = restoring division, WIDTH iterations.
  - result = quotient; carry = (remainder != 0).
  - b == 0: 1 iteration, result = all ones, err=1.
- Undefined: op 111 takes 1 iteration, result=0, carry=0, zero=1, err=1; no divider logic is synthesized.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD … OP_DIV);
  - state encoding (ST_IDLE, ST_RUN);
  - default WIDTH.
- One natural sub-module, alu_iter_unit:
  - shared accumulator/shift datapath for SHL/MUL/DIV, stepped by an iterate strobe.
  - seq_alu keeps the FSM, counter, single-cycle ops, flags and output registers.

Test Plan:
- ADD a=0xF0, b=0x20 -> done 1 cycle after start; result=0x10, carry=1, zero=0, busy high exactly 1 cycle.
- SUB 0x05-0x05 -> result=0x00, zero=1, carry=0; then SUB 0x03-0x05 back-to-back (start during done) -> result=0xFE, carry=1.
- MUL 0x0C*0x0B -> done 8 cycles after start; result=0x84, carry=0. MUL 0x20*0x10 -> result=0x00, carry=1, zero=1.
- SHL 0x81 by b=3 -> done after 3 cycles; result=0x08, carry=0. start asserted mid-operation with ADD is ignored, and result stays 0x08.
- Reset mid-MUL: async_reset pulsed 4 cycles after start -> busy=0, result=0 immediately, no done pulse; a new ADD 1+1 afterwards yields 0x02.
- DIV with SEQ_ALU_DIV_EN: 0x64/0x07 -> result=0x0E, carry=1, err=0 after 8 cycles; /0 -> result=0xFF, err=1 after 1 cycle. DIV without the macro -> result=0x00, err=1 after 1 cycle.
